// File: rtl/mem_size_pkg.sv
// Shared definitions for the load/store size paths of the multicycle CPU.
//   LS_*    : 2-bit size command encoding, identical on load and store sides
//   state_e : store_size_unit FSM state encoding
package mem_size_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;
    localparam logic [1:0] LS_INV  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

endpackage

// File: rtl/store_merge.sv
// Combinational merge of register data into a memory word for sized stores.
// Ports:
//   rd     in  32  word read back from memory
//   wd     in  32  register data being stored
//   cmd    in  2   size command (LS_BYTE / LS_HALF / LS_WORD)
//   merged out 32  word to write back
// Lanes are always the low byte/half; the address does not steer them.
module store_merge
    import mem_size_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [31:0] wd,
    input  logic [1:0]  cmd,
    output logic [31:0] merged
);

    always_comb begin
        merged = wd;
        case (cmd)
            LS_BYTE: merged = {rd[31:8], wd[7:0]};
            LS_HALF: merged = {rd[31:16], wd[15:0]};
            default: merged = wd;
        endcase
    end

endmodule

// File: rtl/store_size_unit.sv
// Store-side size unit: writes byte/half/word register data to memory.
// Word stores are written directly; byte/half stores read the word, merge
// the low lane(s) of the register data and write the result back.
// Ports:
//   clk        in   1       rising-edge clock
//   reset_n    in   1       asynchronous active-low reset
//   start      in   1       request, sampled only while idle
//   command    in   2       00 byte, 01 half, 10 word, 11 invalid
//   addr       in   ADDR_W  store address, latched on accept
//   wdata      in   32      register data, latched on accept
//   mem_rdata  in   32      memory read data (MEM_RD_LAT cycles after mem_addr)
//   mem_addr   out  ADDR_W  latched store address
//   mem_wr     out  1       memory write enable (one cycle)
//   mem_wdata  out  32      memory write data
//   busy       out  1       operation in progress
//   done       out  1       one-cycle completion pulse
//   err        out  1       with done: command was invalid
module store_size_unit
    import mem_size_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        command,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // One spare bit so the counter can never wrap while waiting for read data.
    localparam int               CNT_W    = $clog2(MEM_RD_LAT + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_LAT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       merged;

    store_merge u_merge (
        .rd     (mem_rdata),
        .wd     (wdata_q),
        .cmd    (cmd_q),
        .merged (merged)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cmd_d       = cmd_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    cmd_d   = command;
                    case (command)
                        LS_WORD: begin
                            state_d     = ST_WRITE;
                            mem_wdata_d = wdata;
                        end
                        LS_BYTE, LS_HALF: begin
                            state_d = ST_READ;
                            cnt_d   = '0;
                        end
                        default: begin
                            // Invalid size: report immediately, never touch memory.
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end
                    endcase
                end
            end
            ST_READ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Read data is valid exactly when the counter reaches the latency.
                if (cnt_q == CNT_LAST) begin
                    mem_wdata_d = merged;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_q       <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmd_q       <= cmd_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Decoded from state so a reset mid-write removes the strobe at once.
    assign mem_wr    = (state_q == ST_WRITE);
    assign busy      = (state_q != ST_IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_size_unit.sv
// Bench for store_size_unit: two instances (read latency 1 and 3), each
// with its own behavioural memory, driven by directed and random stores.
module tb_store_size_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [1:0]  command = 2'b00;
    logic [31:0] addr = '0, wdata = '0;

    logic [31:0] mem_rdata_a, mem_addr_a, mem_wdata_a;
    logic        mem_wr_a, busy_a, done_a, err_a;
    logic [31:0] mem_rdata_b, mem_addr_b, mem_wdata_b;
    logic        mem_wr_b, busy_b, done_b, err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_size_unit #(.MEM_RD_LAT(1), .ADDR_W(32)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .command(command),
        .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata_a),
        .mem_addr(mem_addr_a), .mem_wr(mem_wr_a), .mem_wdata(mem_wdata_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    store_size_unit #(.MEM_RD_LAT(3), .ADDR_W(32)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .command(command),
        .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata_b),
        .mem_addr(mem_addr_b), .mem_wr(mem_wr_b), .mem_wdata(mem_wdata_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    // Initial memory image (word index = addr[9:2]).
    function automatic logic [31:0] init_val(input logic [7:0] i);
        if (i == 8'h11 || i == 8'h12) return 32'h11223344;
        return {i, ~i, i ^ 8'h5A, 8'hC3};
    endfunction

    // ---------------- memory models ----------------
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    bit          wf_a  [256];
    bit          wf_b  [256];
    logic [31:0] rd_a, p1_b, p2_b, p3_b;
    int          wr_cnt_a = 0, wr_cnt_b = 0, busy_cyc_a = 0, busy_cyc_b = 0;
    logic [31:0] wa_addr_a, wa_data_a, wa_addr_b, wa_data_b;

    function automatic logic [31:0] mem_a_rd(input logic [7:0] i);
        return wf_a[i] ? mem_a[i] : init_val(i);
    endfunction
    function automatic logic [31:0] mem_b_rd(input logic [7:0] i);
        return wf_b[i] ? mem_b[i] : init_val(i);
    endfunction

    always @(posedge clk) begin
        rd_a <= mem_a_rd(mem_addr_a[9:2]);
        if (mem_wr_a) begin
            mem_a[mem_addr_a[9:2]] <= mem_wdata_a;
            wf_a[mem_addr_a[9:2]]  <= 1'b1;
            wr_cnt_a  <= wr_cnt_a + 1;
            wa_addr_a <= mem_addr_a;
            wa_data_a <= mem_wdata_a;
        end
        if (busy_a) busy_cyc_a <= busy_cyc_a + 1;
    end

    always @(posedge clk) begin
        p1_b <= mem_b_rd(mem_addr_b[9:2]);
        p2_b <= p1_b;
        p3_b <= p2_b;
        if (mem_wr_b) begin
            mem_b[mem_addr_b[9:2]] <= mem_wdata_b;
            wf_b[mem_addr_b[9:2]]  <= 1'b1;
            wr_cnt_b  <= wr_cnt_b + 1;
            wa_addr_b <= mem_addr_b;
            wa_data_b <= mem_wdata_b;
        end
        if (busy_b) busy_cyc_b <= busy_cyc_b + 1;
    end

    assign mem_rdata_a = rd_a;
    assign mem_rdata_b = p3_b;

    // ---------------- reference memory ----------------
    logic [31:0] ref_a [256];
    logic [31:0] ref_b [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete store on instance a (sel_b=0) or b (sel_b=1).
    // disturb keeps start high with junk operands during the first busy cycles.
    task automatic op(input bit sel_b, input logic [1:0] c, input logic [31:0] a,
                      input logic [31:0] d, input bit disturb);
        int          lat, exp_n, n, wr0, busy0;
        logic [31:0] old, exp_w;
        logic [7:0]  idx;
        bit          seen;
        lat   = sel_b ? 3 : 1;
        idx   = a[9:2];
        old   = sel_b ? ref_b[idx] : ref_a[idx];
        case (c)
            2'b00:   exp_w = (old & 32'hFFFF_FF00) | (d & 32'h0000_00FF);
            2'b01:   exp_w = (old & 32'hFFFF_0000) | (d & 32'h0000_FFFF);
            2'b10:   exp_w = d;
            default: exp_w = old;
        endcase
        exp_n = (c == 2'b10) ? 2 : (c == 2'b11) ? 1 : lat + 3;
        wr0   = sel_b ? wr_cnt_b : wr_cnt_a;
        busy0 = sel_b ? busy_cyc_b : busy_cyc_a;

        @(negedge clk);
        command = c; addr = a; wdata = d;
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 12) begin
            @(negedge clk);
            n++;
            seen = sel_b ? done_b : done_a;
            if (sel_b) start_b = disturb && n <= 2 && !seen;
            else       start_a = disturb && n <= 2 && !seen;
            command = 2'($urandom); addr = $urandom; wdata = $urandom;
        end
        chk("latency", 32'(n), 32'(exp_n));
        chk("err", {31'b0, sel_b ? err_b : err_a}, {31'b0, c == 2'b11});
        chk("writes", 32'((sel_b ? wr_cnt_b : wr_cnt_a) - wr0), (c == 2'b11) ? 32'd0 : 32'd1);
        chk("busy_cycles", 32'((sel_b ? busy_cyc_b : busy_cyc_a) - busy0), 32'(exp_n - 1));
        if (c != 2'b11) begin
            chk("wr_addr", sel_b ? wa_addr_b : wa_addr_a, a);
            chk("wr_data", sel_b ? wa_data_b : wa_data_a, exp_w);
            if (sel_b) ref_b[idx] = exp_w; else ref_a[idx] = exp_w;
        end
        @(negedge clk);
        chk("done_pulse", {31'b0, sel_b ? done_b : done_a}, 32'd0);
        chk("idle_after", {31'b0, sel_b ? busy_b : busy_a}, 32'd0);
        $display("op inst=%0d cmd=%0d addr=%h wdata=%h latency=%0d expected_word=%h",
                 sel_b, c, a, d, n, exp_w);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            ref_a[i] = init_val(8'(i));
            ref_b[i] = init_val(8'(i));
        end

        // Reset state
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_wr", {31'b0, mem_wr_a}, 32'd0);
        chk("rst_busy", {31'b0, busy_a}, 32'd0);
        chk("rst_done", {31'b0, done_a | err_a}, 32'd0);
        chk("rst_mem_addr", mem_addr_a, 32'd0);
        chk("rst_mem_wdata", mem_wdata_b, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed: sw, sb, sh (both latencies), invalid, start during READ
        op(1'b0, 2'b10, 32'h40, 32'hDEADBEEF, 1'b0);
        chk("sw_const", wa_data_a, 32'hDEADBEEF);
        op(1'b0, 2'b00, 32'h44, 32'hAABBCCDD, 1'b0);
        chk("sb_const", wa_data_a, 32'h112233DD);
        op(1'b0, 2'b01, 32'h48, 32'hAABBCCDD, 1'b0);
        chk("sh_const", wa_data_a, 32'h1122CCDD);
        op(1'b1, 2'b01, 32'h48, 32'hAABBCCDD, 1'b0);
        chk("sh_lat3_const", wa_data_b, 32'h1122CCDD);
        op(1'b0, 2'b11, 32'h4C, 32'h55555555, 1'b0);
        op(1'b0, 2'b00, 32'h100, 32'h12345678, 1'b1);
        repeat (3) @(negedge clk);
        chk("no_extra_op", {31'b0, busy_a}, 32'd0);

        // Reset during WRITE
        @(negedge clk);
        command = 2'b10; addr = 32'h80; wdata = 32'hCAFEF00D; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("pre_rst_mem_wr", {31'b0, mem_wr_a}, 32'd1);
        n = wr_cnt_a;
        reset_n = 1'b0;
        #1;
        chk("midrst_mem_wr", {31'b0, mem_wr_a}, 32'd0);
        chk("midrst_busy", {31'b0, busy_a}, 32'd0);
        chk("midrst_done", {31'b0, done_a | err_a}, 32'd0);
        chk("midrst_addr", mem_addr_a, 32'd0);
        chk("midrst_wdata", mem_wdata_a, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("aborted_write", 32'(wr_cnt_a - n), 32'd0);
        op(1'b0, 2'b10, 32'h84, 32'h0BADC0DE, 1'b0);

        // Back-to-back: start held, sw then sb accepted on the done cycle
        @(negedge clk);
        n = wr_cnt_a;
        command = 2'b10; addr = 32'h90; wdata = 32'h01020304; start_a = 1'b1;
        @(negedge clk);
        command = 2'b00; addr = 32'h94; wdata = 32'hF0F0F0A5;
        chk("b2b_busy", {31'b0, busy_a}, 32'd1);
        @(negedge clk);
        chk("b2b_done1", {31'b0, done_a}, 32'd1);
        chk("b2b_wr1_addr", wa_addr_a, 32'h90);
        chk("b2b_wr1_data", wa_data_a, 32'h01020304);
        ref_a[8'h24] = 32'h01020304;
        n = 0;
        begin
            bit seen;
            seen = 1'b0;
            while (!seen && n < 12) begin
                @(negedge clk);
                n++;
                start_a = 1'b0;
                seen = done_a;
            end
        end
        chk("b2b_latency2", 32'(n), 32'd4);
        chk("b2b_wr2_addr", wa_addr_a, 32'h94);
        ref_a[8'h25] = (ref_a[8'h25] & 32'hFFFF_FF00) | 32'h0000_00A5;
        chk("b2b_wr2_data", wa_data_a, ref_a[8'h25]);
        @(negedge clk);

        // Random stores against the reference memory
        for (int k = 0; k < 40; k++) begin
            op(1'($urandom), 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
        end

        // Whole-memory comparison
        for (int i = 0; i < 256; i++) begin
            chk("mem_a_final", mem_a_rd(8'(i)), ref_a[i]);
            chk("mem_b_final", mem_b_rd(8'(i)), ref_b[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
